// File: rtl/memory_unit_if.sv
// Request/response bus between the processor datapath and memory_unit.
// The master side issues requests; the slave side is the memory.
interface memory_unit_if;
  logic        read_req;
  logic        write_req;
  logic        write_byte;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] out_mem;
  logic        ready_mem;
  logic        finished_memwrite;
  logic        busy;

  modport master (
    output read_req, write_req, write_byte, addr, write_data,
    input  out_mem, ready_mem, finished_memwrite, busy
  );

  modport slave (
    input  read_req, write_req, write_byte, addr, write_data,
    output out_mem, ready_mem, finished_memwrite, busy
  );
endinterface

// File: rtl/memory_unit.sv
// Synchronous single-port word memory with word reads, word writes and
// byte writes; byte writes run as a read-modify-write through the same port.
module memory_unit #(
  parameter int WORD_ADDR_BITS = 10,
  parameter int READ_LATENCY   = 2
) (
  input  logic         clock,
  input  logic         reset,
  memory_unit_if.slave bus
);
  localparam int         DEPTH = 1 << WORD_ADDR_BITS;
  localparam logic [3:0] LAT   = 4'(READ_LATENCY);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_WAIT  = 3'd1,
    WRITE_WORD = 3'd2,
    RMW_READ   = 3'd3,
    RMW_WRITE  = 3'd4
  } state_t;

  // Replace one little-endian byte lane of a word.
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [7:0]  data,
                                             input logic [1:0]  lane);
    logic [31:0] merged;
    merged = word;
    case (lane)
      2'd0:    merged[7:0]   = data;
      2'd1:    merged[15:8]  = data;
      2'd2:    merged[23:16] = data;
      2'd3:    merged[31:24] = data;
      default: merged        = word;
    endcase
    return merged;
  endfunction

  state_t                    state_r;
  state_t                    state_next_s;
  logic [3:0]                cnt_r;
  logic [3:0]                cnt_next_s;
  logic [WORD_ADDR_BITS-1:0] idx_r;
  logic [1:0]                lane_r;
  logic [31:0]               data_r;
  logic [31:0]               mem_r [DEPTH];
  logic [31:0]               out_mem_r;
  logic [31:0]               rmw_word_r;
  logic                      ready_mem_r;
  logic                      finished_r;
  logic                      busy_r;
  logic [WORD_ADDR_BITS-1:0] ram_idx_s;
  logic                      we_s;
  logic [31:0]               wr_word_s;
  logic                      ready_next_s;
  logic                      finished_next_s;
  logic                      busy_next_s;
  logic                      ld_rmw_s;
  logic                      unused_addr_s;

  // FSM state and in-transaction cycle counter (cycle 1 follows acceptance)
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state decode; a write beats a simultaneous read
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r + 4'd1;
    case (state_r)
      IDLE: begin
        cnt_next_s = 4'd1;
        if (bus.write_req) begin
          if (bus.write_byte) begin
            state_next_s = RMW_READ;
          end else begin
            state_next_s = WRITE_WORD;
          end
        end else if (bus.read_req) begin
          state_next_s = READ_WAIT;
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = 4'd0;
        end
      end
      READ_WAIT: begin
        if (cnt_r == LAT) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = READ_WAIT;
        end
      end
      WRITE_WORD: state_next_s = IDLE;
      RMW_READ: begin
        if (cnt_r == LAT) begin
          state_next_s = RMW_WRITE;
        end else begin
          state_next_s = RMW_READ;
        end
      end
      RMW_WRITE: state_next_s = IDLE;
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // RAM port control and next values of the registered outputs
  always_comb begin
    if (state_r == IDLE) begin
      ram_idx_s = bus.addr[WORD_ADDR_BITS+1:2];
    end else begin
      ram_idx_s = idx_r;
    end
    // reset wins over a commit landing on the same edge
    we_s            = !reset && ((state_r == WRITE_WORD) || (state_r == RMW_WRITE));
    wr_word_s       = (state_r == RMW_WRITE) ? merge_byte(rmw_word_r, data_r[7:0], lane_r)
                                             : data_r;
    ready_next_s    = (state_next_s == READ_WAIT) && (cnt_next_s == LAT);
    finished_next_s = (state_next_s == WRITE_WORD) || (state_next_s == RMW_WRITE);
    busy_next_s     = (state_next_s != IDLE);
    ld_rmw_s        = (state_r == RMW_READ) && (state_next_s == RMW_WRITE);
  end

  // Capture the request on the accepting edge; later input changes are ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_r  <= '0;
      lane_r <= 2'd0;
      data_r <= 32'd0;
    end else if ((state_r == IDLE) && (bus.write_req || bus.read_req)) begin
      idx_r  <= bus.addr[WORD_ADDR_BITS+1:2];
      lane_r <= bus.addr[1:0];
      data_r <= bus.write_data;
    end
  end

  // RAM array write port; contents survive reset
  always_ff @(posedge clock) begin
    if (we_s) begin
      mem_r[ram_idx_s] <= wr_word_s;
    end
  end

  // Registered read data: out_mem only on read completion, rmw_word for merges
  always_ff @(posedge clock) begin
    if (reset) begin
      out_mem_r  <= 32'd0;
      rmw_word_r <= 32'd0;
    end else begin
      if (ready_next_s) begin
        out_mem_r <= mem_r[ram_idx_s];
      end
      if (ld_rmw_s) begin
        rmw_word_r <= mem_r[ram_idx_s];
      end
    end
  end

  // Status pulses and busy flag
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_mem_r <= 1'b0;
      finished_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      ready_mem_r <= ready_next_s;
      finished_r  <= finished_next_s;
      busy_r      <= busy_next_s;
    end
  end

  assign bus.out_mem           = out_mem_r;
  assign bus.ready_mem         = ready_mem_r;
  assign bus.finished_memwrite = finished_r;
  assign bus.busy              = busy_r;

  // upper address bits alias onto the same words
  assign unused_addr_s = ^bus.addr[31:WORD_ADDR_BITS+2];
endmodule

// File: tb/tb_memory_unit.sv
// Directed and randomized checks of memory_unit against a transaction-level
// model: each accepted request has a known duration and completion effect.
module tb_memory_unit;
  localparam int WAB   = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << WAB;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memory_unit_if bus_if ();
  memory_unit #(.WORD_ADDR_BITS(WAB), .READ_LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;
  int ready_count = 0;

  // Model: m_k is the cycle number inside the current transaction (0 = idle),
  // m_n its length; the transaction's effect lands on the edge ending cycle m_n.
  logic [31:0]    mem_model [DEPTH];
  int             m_k = 0;
  int             m_n = 0;
  int             m_kind = 0;      // 0 read, 1 word write, 2 byte write
  logic [WAB-1:0] m_idx;
  logic [1:0]     m_lane;
  logic [31:0]    m_data;
  logic [31:0]    m_out = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_k   <= 0;
      m_out <= 32'h0;
    end else if (m_k == 0) begin
      if (bus_if.write_req || bus_if.read_req) begin
        m_kind <= bus_if.write_req ? (bus_if.write_byte ? 2 : 1) : 0;
        m_n    <= bus_if.write_req ? (bus_if.write_byte ? LAT + 1 : 1) : LAT;
        m_k    <= 1;
        m_idx  <= bus_if.addr[WAB+1:2];
        m_lane <= bus_if.addr[1:0];
        m_data <= bus_if.write_data;
      end
    end else if (m_k == m_n) begin
      m_k <= 0;
      if (m_kind == 0) m_out <= mem_model[m_idx];
      else if (m_kind == 1) mem_model[m_idx] <= m_data;
      else mem_model[m_idx][8*m_lane +: 8] <= m_data[7:0];
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      check("busy", 32'(bus_if.busy), 32'(m_k != 0));
      check("ready_mem", 32'(bus_if.ready_mem), 32'(m_k != 0 && m_kind == 0 && m_k == m_n));
      check("finished_memwrite", 32'(bus_if.finished_memwrite),
            32'(m_k != 0 && m_kind != 0 && m_k == m_n));
      check("out_mem", bus_if.out_mem,
            (m_k != 0 && m_kind == 0 && m_k == m_n) ? mem_model[m_idx] : m_out);
      if (bus_if.ready_mem === 1'b1) ready_count++;
    end
  end

  // Issue one request from an idle cycle, hold it until a pulse, then drop it.
  task automatic do_req(input bit rd, input bit wr, input bit wb, input logic [31:0] a,
                        input logic [31:0] d, output int pc, output bit gr, output bit gf);
    bus_if.read_req   = rd;
    bus_if.write_req  = wr;
    bus_if.write_byte = wb;
    bus_if.addr       = a;
    bus_if.write_data = d;
    pc = -1; gr = 1'b0; gf = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus_if.ready_mem === 1'b1 || bus_if.finished_memwrite === 1'b1) begin
        pc = i;
        gr = bus_if.ready_mem;
        gf = bus_if.finished_memwrite;
        break;
      end
    end
    @(posedge clock); #1;
    bus_if.read_req   = 1'b0;
    bus_if.write_req  = 1'b0;
    bus_if.write_byte = 1'b0;
    if (pc < 0) begin
      total++;
      bad++;
      $display("FAIL pulse_timeout: got no pulse within 20 cycles, addr %h", a);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  int pc;
  bit gr, gf;
  int rc0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
    bus_if.read_req = 1'b0; bus_if.write_req = 1'b0; bus_if.write_byte = 1'b0;
    bus_if.addr = 32'h0; bus_if.write_data = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    checking = 1'b1;

    repeat (5) @(posedge clock);
    #1;
    check("idle_out_mem", bus_if.out_mem, 32'h0);
    check("idle_busy", 32'(bus_if.busy), 32'h0);

    do_req(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, pc, gr, gf);
    check("word_write_cycle", pc, 32'd1);
    check("word_write_fin", 32'(gf), 32'd1);
    do_req(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, pc, gr, gf);
    check("read_cycle", pc, 32'(LAT));
    check("read_data", bus_if.out_mem, 32'hDEADBEEF);

    do_req(1'b0, 1'b1, 1'b1, 32'h11, 32'hFFFFFF55, pc, gr, gf);
    check("byte_write_cycle", pc, 32'(LAT + 1));
    check("model_merge", mem_model[4], 32'hDEAD55EF);
    do_req(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, pc, gr, gf);
    check("byte_read_data", bus_if.out_mem, 32'hDEAD55EF);

    do_req(1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678, pc, gr, gf);
    check("both_fin", 32'(gf), 32'd1);
    check("both_no_ready", 32'(gr), 32'd0);
    check("both_out_held", bus_if.out_mem, 32'hDEAD55EF);
    do_req(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, pc, gr, gf);
    check("both_read_data", bus_if.out_mem, 32'h12345678);

    // byte write aborted by reset in cycle 2
    bus_if.write_req = 1'b1; bus_if.write_byte = 1'b1;
    bus_if.addr = 32'h13; bus_if.write_data = 32'hAA;
    @(posedge clock); #1;
    bus_if.write_req = 1'b0; bus_if.write_byte = 1'b0;
    @(posedge clock); #1;
    pulse_reset();
    check("abort_busy", 32'(bus_if.busy), 32'h0);
    do_req(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, pc, gr, gf);
    check("abort_read_data", bus_if.out_mem, 32'hDEAD55EF);

    do_req(1'b0, 1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, pc, gr, gf);
    do_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, pc, gr, gf);
    check("wrap_read_data", bus_if.out_mem, 32'hCAFEF00D);

    // second read_req while busy, with changed addr, must be ignored
    rc0 = ready_count;
    bus_if.read_req = 1'b1; bus_if.addr = 32'h20;
    @(posedge clock); #1;
    bus_if.read_req = 1'b0; bus_if.addr = 32'h10;
    #2 bus_if.read_req = 1'b1;
    for (int i = 0; i < 20 && bus_if.ready_mem !== 1'b1; i++) @(negedge clock);
    @(posedge clock); #1;
    bus_if.read_req = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    check("busy_read_pulses", ready_count - rc0, 32'd1);
    check("busy_read_data", bus_if.out_mem, 32'h12345678);

    // fill every word, using random high address bits to exercise aliasing
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] a;
      a = $urandom;
      a[WAB+1:2] = i[WAB-1:0];
      do_req(1'b0, 1'b1, 1'b0, a, $urandom, pc, gr, gf);
    end

    for (int n = 0; n < 400; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if (n % 25 == 24) begin
        bus_if.write_req = (kind != 0); bus_if.read_req = (kind == 0);
        bus_if.write_byte = kind[0]; bus_if.addr = a; bus_if.write_data = $urandom;
        @(posedge clock); #1;
        bus_if.write_req = 1'b0; bus_if.read_req = 1'b0; bus_if.write_byte = 1'b0;
        repeat ($urandom_range(0, LAT)) begin @(posedge clock); #1; end
        pulse_reset();
      end else begin
        case (kind)
          0:       do_req(1'b1, 1'b0, 1'b0, a, $urandom, pc, gr, gf);
          1:       do_req(1'b0, 1'b1, 1'b0, a, $urandom, pc, gr, gf);
          2:       do_req(1'b0, 1'b1, 1'b1, a, $urandom, pc, gr, gf);
          default: do_req(1'b1, 1'b1, 1'(a[4]), a, $urandom, pc, gr, gf);
        endcase
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    repeat (3) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Synchronous on-chip data/instruction memory serving the processor's controller and datapath.
- Accepts word reads, word writes and byte writes from the datapath.
- Returns read data as out_mem with a one-cycle ready_mem pulse, and signals write completion with a one-cycle finished_memwrite pulse.
- Byte writes are implemented internally as read-modify-write sequences.

Parameters:
WORD_ADDR_BITS, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KiB)
READ_LATENCY, 2, cycles from request acceptance to ready_mem (legal range 1..8)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
read_req  input  1  level request for a word read
write_req  input  1  level request for a write
write_byte  input  1  with write_req: 1 = byte write, 0 = word write
addr  input  32  byte address
write_data  input  32  word write data; byte write uses bits 7:0
out_mem  output  32  registered read data
ready_mem  output  1  one-cycle pulse, out_mem valid
finished_memwrite  output  1  one-cycle pulse, write committed
busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Addressing:
  - Word index = addr[WORD_ADDR_BITS+1:2]. Bits above it are ignored, so addresses alias/wrap modulo depth.
  - Byte lane = addr[1:0], little-endian (lane 0 = bits 7:0, lane 3 = bits 31:24).
  - Word accesses ignore addr[1:0] and are always aligned.
- FSM states: IDLE, READ_WAIT, WRITE_WORD, RMW_READ, RMW_WRITE.
- Acceptance:
  - Requests are sampled only in IDLE.
  - On the accepting edge, addr, write_data and write_byte are latched.
  - Input changes while busy are ignored. Requests while busy are dropped, not queued.
- Simultaneous read_req and write_req in IDLE: the write wins and the read is not performed.
- Cycle numbering: cycle 1 is the first cycle after the accepting edge.
- Read: IDLE -> READ_WAIT.
  - ready_mem = 1 and out_mem = word in cycle READ_LATENCY, then IDLE.
  - out_mem holds its value until the next read completes.
  - Writes never change out_mem.
- Word write: IDLE -> WRITE_WORD.
  - The RAM word is written on the edge ending cycle 1.
  - finished_memwrite = 1 in cycle 1, then IDLE.
- Byte write: IDLE -> RMW_READ for READ_LATENCY cycles, then RMW_WRITE.
  - In RMW_WRITE (cycle READ_LATENCY+1): merge write_data[7:0] into the selected lane of the fetched word, write it on the edge ending that cycle, and assert finished_memwrite = 1.
  - The other three bytes are preserved exactly. Then IDLE.
- Pulse width: ready_mem and finished_memwrite are each high for exactly one cycle per accepted request and are never high together.
- Back-to-back requests: the FSM is back in IDLE the cycle after a pulse. A requester still asserting a request there starts a new transaction, so requesters drop their request on seeing the pulse.
- Read-after-write: a read accepted after finished_memwrite returns the newly written data.
- Reset:
  - Reset values: state IDLE, out_mem = 0, ready_mem = 0, finished_memwrite = 0, busy = 0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts the transaction. A write not yet committed (any cycle before its commit edge) leaves RAM unchanged, and no pulse is emitted.
  - Reset has priority over a commit in the same cycle.
- Memory is inferred as single-port synchronous RAM.
  - Read-during-write never occurs because the FSM serialises accesses.
  - Optional initialisation is by file load in simulation only.

Test Plan:
- Reset, then idle 5 cycles -> out_mem = 0x00000000; ready_mem, finished_memwrite and busy stay 0.
- Word write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> finished_memwrite in cycle 1; ready_mem in cycle 2 (READ_LATENCY = 2) with out_mem = 0xDEADBEEF.
- After the previous step, byte write 0x55 to addr 0x11, then read 0x10 -> finished_memwrite in cycle 3; out_mem = 0xDEAD55EF.
- read_req and write_req together, addr 0x20, write_data 0x12345678 -> only finished_memwrite pulses, no ready_mem; a subsequent read of 0x20 returns 0x12345678 and out_mem is unchanged until then.
- Byte write 0xAA to addr 0x13 with reset asserted in cycle 2 -> no pulse, busy = 0 next cycle, and a read of 0x10 still returns 0xDEAD55EF.
- Word write 0xCAFEF00D to addr 0x1000, then read addr 0x0 -> 0xCAFEF00D (wrap with WORD_ADDR_BITS = 10). A second read_req asserted while busy -> ignored, exactly one ready_mem pulse.
